// File: rtl/bcd_countdown_timer_if.sv
// Control and status bundle for the BCD MM:SS countdown timer.
// master: the controlling side drives pulses and preset, observes status.
// slave : the timer consumes pulses/preset and drives count and status flags.
interface bcd_countdown_timer_if;
  logic        tick_in;   // timebase enable pulse
  logic [15:0] preset;    // BCD MM:SS preset from the adder stage
  logic        load;      // capture preset
  logic        start;     // run or resume
  logic        pause;     // pause
  logic        clear;     // abort and zero
  logic [15:0] count;     // current BCD MM:SS value
  logic        running;   // high while counting
  logic        expired;   // high while sitting at 00:00 after expiry
  logic        done;      // one-cycle pulse on reaching 00:00
  logic        load_err;  // one-cycle pulse on a rejected load

  modport master (
    output tick_in, preset, load, start, pause, clear,
    input  count, running, expired, done, load_err
  );

  modport slave (
    input  tick_in, preset, load, start, pause, clear,
    output count, running, expired, done, load_err
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// BCD MM:SS countdown timer: holds a loaded preset, decrements once per
// TICKS_PER_SEC tick_in pulses while running, and flags expiry at 00:00.
// Ports: clk, reset (sync, active-high), bus (slave modport of bcd_countdown_timer_if).
// Latency: every output is registered and reflects an event one edge after it.
module bcd_countdown_timer #(
  parameter int TICKS_PER_SEC = 1
) (
  input logic                  clk,
  input logic                  reset,
  bcd_countdown_timer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READY  = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSED = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [9:0] LP_LAST = 10'(TICKS_PER_SEC - 1);

  state_t      r_state;
  logic [15:0] r_count;
  logic [9:0]  r_presc;
  logic        r_running;
  logic        r_expired;
  logic        r_done;
  logic        r_load_err;

  state_t      w_state_nx;
  logic [15:0] w_count_nx;
  logic [9:0]  w_presc_nx;
  logic        w_done_nx;
  logic        w_err_nx;
  logic        w_preset_ok;
  logic [15:0] w_count_dec;

  // One-second BCD decrement with borrow through the four digits.
  // Only applied to a nonzero count, so the top digit never underflows.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (v[11:8] != 4'd0) begin
          r[11:8] = v[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = v[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign w_preset_ok = (bus.preset[15:12] <= 4'd9) && (bus.preset[11:8] <= 4'd9) &&
                       (bus.preset[7:4]   <= 4'd5) && (bus.preset[3:0]  <= 4'd9);
  assign w_count_dec = bcd_dec(r_count);

  // Next-state logic: only the highest-priority event of the cycle acts.
  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    w_presc_nx = r_presc;
    w_done_nx  = 1'b0;
    w_err_nx   = 1'b0;

    if (bus.clear) begin
      w_state_nx = S_IDLE;
      w_count_nx = 16'h0000;
      w_presc_nx = 10'd0;
    end else if (bus.load) begin
      if (w_preset_ok) begin
        w_count_nx = bus.preset;
        w_presc_nx = 10'd0;
        w_state_nx = (bus.preset != 16'h0000) ? S_READY : S_IDLE;
      end else begin
        w_err_nx = 1'b1;
      end
    end else if (bus.pause) begin
      // Prescaler is left alone so a resume finishes the partial second.
      if (r_state == S_RUN) begin
        w_state_nx = S_PAUSED;
      end
    end else if (bus.start) begin
      if (r_state == S_READY) begin
        w_state_nx = S_RUN;
        w_presc_nx = 10'd0;
      end else if (r_state == S_PAUSED) begin
        // Resume keeps the ticks accumulated before the pause.
        w_state_nx = S_RUN;
      end
    end else if (bus.tick_in && (r_state == S_RUN)) begin
      if (r_presc >= LP_LAST) begin
        w_presc_nx = 10'd0;
        w_count_nx = w_count_dec;
        if (w_count_dec == 16'h0000) begin
          w_state_nx = S_DONE;
          w_done_nx  = 1'b1;
        end
      end else begin
        w_presc_nx = r_presc + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= 16'h0000;
      r_presc    <= 10'd0;
      r_running  <= 1'b0;
      r_expired  <= 1'b0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_count    <= w_count_nx;
      r_presc    <= w_presc_nx;
      r_running  <= (w_state_nx == S_RUN);
      r_expired  <= (w_state_nx == S_DONE);
      r_done     <= w_done_nx;
      r_load_err <= w_err_nx;
    end
  end

  assign bus.count    = r_count;
  assign bus.running  = r_running;
  assign bus.expired  = r_expired;
  assign bus.done     = r_done;
  assign bus.load_err = r_load_err;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Testbench for bcd_countdown_timer: two instances (TICKS_PER_SEC 1 and 4)
// driven with identical stimulus and compared against a seconds-based model,
// plus a vector table and hand-written corner-case sequences.
module tb_bcd_countdown_timer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bcd_countdown_timer_if if1 ();
  bcd_countdown_timer_if if4 ();

  bcd_countdown_timer #(.TICKS_PER_SEC(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  bcd_countdown_timer #(.TICKS_PER_SEC(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));

  int checks = 0;
  int errors = 0;

  // Model modes
  localparam int M_IDLE = 0, M_READY = 1, M_RUN = 2, M_PAUSED = 3, M_DONE = 4;
  int m_mode[2];
  int m_secs[2];
  int m_presc[2];
  bit m_done[2];
  bit m_err[2];
  int m_tps[2] = '{1, 4};

  function automatic int bcd2secs(input logic [15:0] p);
    return (int'(p[15:12]) * 10 + int'(p[11:8])) * 60 + int'(p[7:4]) * 10 + int'(p[3:0]);
  endfunction

  function automatic logic [15:0] secs2bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic bit preset_valid(input logic [15:0] p);
    return (p[15:12] <= 4'd9) && (p[11:8] <= 4'd9) && (p[7:4] <= 4'd5) && (p[3:0] <= 4'd9);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, ld, st, pa, cl, tk, input logic [15:0] pre);
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 1'b0;
      m_err[k]  = 1'b0;
      if (rst || cl) begin
        m_mode[k] = M_IDLE; m_secs[k] = 0; m_presc[k] = 0;
      end else if (ld) begin
        if (preset_valid(pre)) begin
          m_secs[k]  = bcd2secs(pre);
          m_presc[k] = 0;
          m_mode[k]  = (m_secs[k] != 0) ? M_READY : M_IDLE;
        end else begin
          m_err[k] = 1'b1;
        end
      end else if (pa) begin
        if (m_mode[k] == M_RUN) m_mode[k] = M_PAUSED;
      end else if (st) begin
        if (m_mode[k] == M_READY) begin
          m_mode[k] = M_RUN; m_presc[k] = 0;
        end else if (m_mode[k] == M_PAUSED) begin
          m_mode[k] = M_RUN;
        end
      end else if (tk && m_mode[k] == M_RUN) begin
        m_presc[k]++;
        if (m_presc[k] == m_tps[k]) begin
          m_presc[k] = 0;
          m_secs[k]--;
          if (m_secs[k] == 0) begin
            m_mode[k] = M_DONE; m_done[k] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic model_compare();
    chk("t1_count",    if1.count,            secs2bcd(m_secs[0]));
    chk("t1_running",  16'(if1.running),     16'(m_mode[0] == M_RUN));
    chk("t1_expired",  16'(if1.expired),     16'(m_mode[0] == M_DONE));
    chk("t1_done",     16'(if1.done),        16'(m_done[0]));
    chk("t1_load_err", 16'(if1.load_err),    16'(m_err[0]));
    chk("t4_count",    if4.count,            secs2bcd(m_secs[1]));
    chk("t4_running",  16'(if4.running),     16'(m_mode[1] == M_RUN));
    chk("t4_expired",  16'(if4.expired),     16'(m_mode[1] == M_DONE));
    chk("t4_done",     16'(if4.done),        16'(m_done[1]));
    chk("t4_load_err", 16'(if4.load_err),    16'(m_err[1]));
  endtask

  // Drive one cycle of stimulus to both instances, advance model, compare.
  task automatic step(input logic rst, ld, st, pa, cl, tk, input logic [15:0] pre);
    reset = rst;
    if1.load = ld; if1.start = st; if1.pause = pa; if1.clear = cl; if1.tick_in = tk; if1.preset = pre;
    if4.load = ld; if4.start = st; if4.pause = pa; if4.clear = cl; if4.tick_in = tk; if4.preset = pre;
    @(posedge clk);
    model_step(rst, ld, st, pa, cl, tk, pre);
    #1;
    model_compare();
  endtask

  task automatic tick();
    step(0, 0, 0, 0, 0, 1, 16'h0000);
  endtask

  // Vector table: stimulus plus expected TICKS_PER_SEC=1 outputs after the edge.
  typedef struct {
    string       name;
    logic        rst, ld, st, pa, cl, tk;
    logic [15:0] pre;
    logic [15:0] e_cnt;
    logic        e_run, e_exp, e_done, e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input logic rst, ld, st, pa, cl, tk,
                              input logic [15:0] pre, input logic [15:0] cnt,
                              input logic run, ex, dn, er);
    vec_t v;
    v.name = nm; v.rst = rst; v.ld = ld; v.st = st; v.pa = pa; v.cl = cl; v.tk = tk;
    v.pre = pre; v.e_cnt = cnt; v.e_run = run; v.e_exp = ex; v.e_done = dn; v.e_err = er;
    return v;
  endfunction

  initial begin
    if1.load = 0; if1.start = 0; if1.pause = 0; if1.clear = 0; if1.tick_in = 0; if1.preset = 0;
    if4.load = 0; if4.start = 0; if4.pause = 0; if4.clear = 0; if4.tick_in = 0; if4.preset = 0;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE; m_secs[k] = 0; m_presc[k] = 0; m_done[k] = 0; m_err[k] = 0;
    end

    //                 name          rst ld st pa cl tk preset    count    run exp dn err
    vecs.push_back(mk("reset",        1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk("start_idle",   0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk("load_0A00",    0, 1, 0, 0, 0, 0, 16'h0A00, 16'h0000, 0, 0, 0, 1));
    vecs.push_back(mk("load_0060",    0, 1, 0, 0, 0, 0, 16'h0060, 16'h0000, 0, 0, 0, 1));
    vecs.push_back(mk("load_0000",    0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk("start_zero",   0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk("load_1000",    0, 1, 0, 0, 0, 0, 16'h1000, 16'h1000, 0, 0, 0, 0));
    vecs.push_back(mk("start_1000",   0, 0, 1, 0, 0, 0, 16'h0000, 16'h1000, 1, 0, 0, 0));
    vecs.push_back(mk("tick_0959",    0, 0, 0, 0, 0, 1, 16'h0000, 16'h0959, 1, 0, 0, 0));
    vecs.push_back(mk("load_2000",    0, 1, 0, 0, 0, 0, 16'h2000, 16'h2000, 0, 0, 0, 0));
    vecs.push_back(mk("start_2000",   0, 0, 1, 0, 0, 0, 16'h0000, 16'h2000, 1, 0, 0, 0));
    vecs.push_back(mk("tick_1959",    0, 0, 0, 0, 0, 1, 16'h0000, 16'h1959, 1, 0, 0, 0));
    vecs.push_back(mk("tick_pause",   0, 0, 0, 1, 0, 1, 16'h0000, 16'h1959, 0, 0, 0, 0));
    vecs.push_back(mk("tick_paused",  0, 0, 0, 0, 0, 1, 16'h0000, 16'h1959, 0, 0, 0, 0));
    vecs.push_back(mk("resume",       0, 0, 1, 0, 0, 0, 16'h0000, 16'h1959, 1, 0, 0, 0));
    vecs.push_back(mk("load_clear",   0, 1, 0, 0, 1, 0, 16'h0500, 16'h0000, 0, 0, 0, 0));
    vecs.push_back(mk("load_0002",    0, 1, 0, 0, 0, 0, 16'h0002, 16'h0002, 0, 0, 0, 0));
    vecs.push_back(mk("start_0002",   0, 0, 1, 0, 0, 0, 16'h0000, 16'h0002, 1, 0, 0, 0));
    vecs.push_back(mk("tick_0001",    0, 0, 0, 0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0, 0));
    vecs.push_back(mk("tick_expire",  0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1, 0));
    vecs.push_back(mk("tick_no_wrap", 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0, 0));
    vecs.push_back(mk("bad_in_done",  0, 1, 0, 0, 0, 0, 16'h0A00, 16'h0000, 0, 1, 0, 1));
    vecs.push_back(mk("clear_done",   0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ld, vecs[i].st, vecs[i].pa, vecs[i].cl, vecs[i].tk, vecs[i].pre);
      chk({vecs[i].name, "_count"},   if1.count,          vecs[i].e_cnt);
      chk({vecs[i].name, "_running"}, 16'(if1.running),   16'(vecs[i].e_run));
      chk({vecs[i].name, "_expired"}, 16'(if1.expired),   16'(vecs[i].e_exp));
      chk({vecs[i].name, "_done"},    16'(if1.done),      16'(vecs[i].e_done));
      chk({vecs[i].name, "_err"},     16'(if1.load_err),  16'(vecs[i].e_err));
    end

    // One-minute countdown at one tick per second.
    step(1, 0, 0, 0, 0, 0, 16'h0000);
    step(0, 1, 0, 0, 0, 0, 16'h0100);
    step(0, 0, 1, 0, 0, 0, 16'h0000);
    chk("min_start", if1.count, 16'h0100);
    for (int i = 1; i <= 60; i++) begin
      tick();
      chk("min_count", if1.count, secs2bcd(60 - i));
      chk("min_done",  16'(if1.done), 16'(i == 60));
    end
    chk("min_expired", 16'(if1.expired), 16'h0001);
    tick();
    chk("min_extra_count", if1.count, 16'h0000);
    chk("min_extra_done",  16'(if1.done), 16'h0000);

    // Pause/resume with four ticks per second.
    step(1, 0, 0, 0, 0, 0, 16'h0000);
    step(0, 1, 0, 0, 0, 0, 16'h0005);
    step(0, 0, 1, 0, 0, 0, 16'h0000);
    tick(); tick();
    step(0, 0, 0, 1, 0, 0, 16'h0000);
    chk("pr_paused_count", if4.count, 16'h0005);
    chk("pr_paused_run",   16'(if4.running), 16'h0000);
    for (int i = 0; i < 5; i++) tick();
    chk("pr_hold_count", if4.count, 16'h0005);
    step(0, 0, 1, 0, 0, 0, 16'h0000);
    tick();
    chk("pr_resume1", if4.count, 16'h0005);
    tick();
    chk("pr_resume2", if4.count, 16'h0004);

    // Reset in the middle of a run.
    step(0, 1, 0, 0, 0, 0, 16'h0300);
    step(0, 0, 1, 0, 0, 0, 16'h0000);
    tick(); tick(); tick();
    chk("rst_pre_count", if1.count, 16'h0257);
    step(1, 0, 0, 0, 0, 0, 16'h0000);
    chk("rst_count",   if1.count, 16'h0000);
    chk("rst_running", 16'(if1.running), 16'h0000);
    chk("rst_expired", 16'(if1.expired), 16'h0000);
    tick();
    chk("rst_tick_count", if1.count, 16'h0000);

    // Randomized stimulus against the model.
    for (int n = 0; n < 3000; n++) begin
      logic rst, ld, st, pa, cl, tk;
      logic [15:0] pre;
      rst = ($urandom_range(0, 199) == 0);
      cl  = ($urandom_range(0, 49) == 0);
      ld  = ($urandom_range(0, 19) == 0);
      st  = ($urandom_range(0, 9) == 0);
      pa  = ($urandom_range(0, 24) == 0);
      tk  = ($urandom_range(0, 1) == 0);
      case ($urandom_range(0, 3))
        0:       pre = 16'($urandom);
        1:       pre = secs2bcd(int'($urandom_range(0, 15)));
        2:       pre = secs2bcd(int'($urandom_range(0, 5999)));
        default: pre = secs2bcd(int'($urandom_range(0, 99)) * 60);
      endcase
      step(rst, ld, st, pa, cl, tk, pre);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
